// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: store-width codes, arbiter
// state, and the store alignment rule.
package dmem_pkg;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_W    = 2'b01;
  localparam logic [1:0] WE_H    = 2'b10;
  localparam logic [1:0] WE_B    = 2'b11;

  typedef enum logic {
    NORMAL    = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_t;

  // Loads and byte stores can never be misaligned.
  function automatic logic misaligned(input logic [1:0] we, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (we)
      WE_W:    bad = (a != 2'b00);
      WE_H:    bad = a[0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_port_resp.sv
// Per-port response registers: completion strobe, load data and error flag,
// all valid one cycle after that port was granted.
module dmem_port_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        granted,
  input  logic        is_load,
  input  logic        err,
  input  logic [31:0] mem_rd,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid  <= 1'b0;
      rdata   <= '0;
      rsp_err <= 1'b0;
    end else begin
      rvalid  <= granted;
      rsp_err <= granted & err;
      // rdata holds its last value while the other port owns the memory.
      if (granted) begin
        rdata <= (is_load && !err) ? mem_rd : 32'h0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between CPU and DMA: CPU-priority
// grant with a starvation override, store alignment check, registered responses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic [1:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,

  input  logic        dma_req,
  input  logic [1:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,

  output logic [1:0]  mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic [1:0] sel_we;
  logic       sel_bad;
  logic       cpu_bad, dma_bad;

  // Grant: priority flips while DMA is being forced through.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state_q == DMA_FORCE) begin
        if (dma_req)      dma_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
      end else begin
        if (cpu_req)      cpu_gnt = 1'b1;
        else if (dma_req) dma_gnt = 1'b1;
      end
    end
  end

  // The counter saturates so a huge STARVE_MAX can never wrap it back to 0.
  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: begin
        if (dma_req && !dma_gnt && (starve_d >= STARVE_LIM)) state_d = DMA_FORCE;
      end
      DMA_FORCE: begin
        if (dma_gnt || !dma_req) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Memory mux: CPU fields are presented whenever DMA is not the winner.
  always_comb begin
    mem_a   = dma_gnt ? dma_addr  : cpu_addr;
    mem_wd  = dma_gnt ? dma_wdata : cpu_wdata;
    sel_we  = dma_gnt ? dma_we    : cpu_we;
    sel_bad = misaligned(sel_we, mem_a[1:0]);
    mem_we  = ((cpu_gnt || dma_gnt) && !sel_bad) ? sel_we : WE_NONE;
  end

  assign cpu_bad = misaligned(cpu_we, cpu_addr[1:0]);
  assign dma_bad = misaligned(dma_we, dma_addr[1:0]);

  dmem_port_resp u_cpu_resp (
    .clk     (clk),
    .reset   (reset),
    .granted (cpu_gnt),
    .is_load (cpu_we == WE_NONE),
    .err     (cpu_bad),
    .mem_rd  (mem_rd),
    .rvalid  (cpu_rvalid),
    .rdata   (cpu_rdata),
    .rsp_err (cpu_err)
  );

  dmem_port_resp u_dma_resp (
    .clk     (clk),
    .reset   (reset),
    .granted (dma_gnt),
    .is_load (dma_we == WE_NONE),
    .err     (dma_bad),
    .mem_rd  (mem_rd),
    .rvalid  (dma_rvalid),
    .rdata   (dma_rdata),
    .rsp_err (dma_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural little-endian data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, dma_req;
  logic [1:0]  cpu_we, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else begin
      case (mem_we)
        2'b01: mem[mem_a[7:2]] <= mem_wd;
        2'b10: if (mem_a[1]) mem[mem_a[7:2]][31:16] <= mem_wd[15:0];
               else          mem[mem_a[7:2]][15:0]  <= mem_wd[15:0];
        2'b11: case (mem_a[1:0])
                 2'b00: mem[mem_a[7:2]][7:0]   <= mem_wd[7:0];
                 2'b01: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
                 2'b10: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
                 default: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
               endcase
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic [1:0] we, input logic [31:0] a, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic [1:0] we, input logic [31:0] a, input logic [31:0] wd);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = wd;
  endtask

  // Expected grant patterns with both ports requesting continuously.
  logic [6:0] starve_cpu;
  logic [6:0] starve_dma;

  initial begin
    starve_cpu = 7'b1101111;   // bit i = cycle i
    starve_dma = 7'b0010000;
    reset = 1'b1;
    set_cpu(1'b1, 2'b00, 32'h0, 32'h0);
    set_dma(1'b1, 2'b00, 32'h4, 32'h0);
    #1;
    check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("rst_mem_we", {30'd0, mem_we}, 32'd0);
    tick();
    check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_err", {31'd0, dma_err}, 32'd0);
    tick();
    reset = 1'b0;
    set_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    set_dma(1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // DMA sw then CPU lw to the same word on the next cycle.
    set_dma(1'b1, 2'b01, 32'h10, 32'h12345678);
    #1;
    check("raw_dma_gnt", {31'd0, dma_gnt}, 32'd1);
    check("raw_cpu_gnt0", {31'd0, cpu_gnt}, 32'd0);
    check("raw_mem_we", {30'd0, mem_we}, 32'd1);
    check("raw_mem_a", mem_a, 32'h10);
    tick();
    check("raw_dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
    check("raw_dma_err", {31'd0, dma_err}, 32'd0);
    check("raw_dma_rdata", dma_rdata, 32'd0);
    set_dma(1'b0, 2'b00, 32'h0, 32'h0);
    set_cpu(1'b1, 2'b00, 32'h10, 32'h0);
    #1;
    check("raw_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("raw_ld_mem_we", {30'd0, mem_we}, 32'd0);
    tick();
    check("raw_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("raw_cpu_rdata", cpu_rdata, 32'h12345678);
    check("raw_dma_rvalid_lo", {31'd0, dma_rvalid}, 32'd0);

    // Misaligned word store is granted but blocked from the memory.
    set_cpu(1'b1, 2'b01, 32'h22, 32'hDEADBEEF);
    #1;
    check("mis_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("mis_mem_we", {30'd0, mem_we}, 32'd0);
    tick();
    check("mis_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("mis_err", {31'd0, cpu_err}, 32'd1);
    check("mis_rdata", cpu_rdata, 32'd0);
    check("mis_mem_word", mem[8], 32'd0);

    // Halfword and byte stores land in the right lanes.
    set_cpu(1'b1, 2'b10, 32'h0E, 32'h0000BEEF);
    #1;
    check("sh_mem_we", {30'd0, mem_we}, 32'd2);
    tick();
    check("sh_err", {31'd0, cpu_err}, 32'd0);
    set_cpu(1'b1, 2'b00, 32'h0C, 32'h0);
    tick();
    check("sh_lw", cpu_rdata, 32'hBEEF0000);
    set_cpu(1'b1, 2'b11, 32'h0D, 32'hFFFFFFAA);
    #1;
    check("sb_mem_we", {30'd0, mem_we}, 32'd3);
    tick();
    set_cpu(1'b1, 2'b00, 32'h0C, 32'h0);
    tick();
    check("sb_lw", cpu_rdata, 32'hBEEFAA00);
    set_cpu(1'b1, 2'b10, 32'h0F, 32'h1234);
    #1;
    check("sh_odd_mem_we", {30'd0, mem_we}, 32'd0);
    tick();
    check("sh_odd_err", {31'd0, cpu_err}, 32'd1);

    // Starvation: DMA forced through on the fifth contended cycle.
    set_cpu(1'b1, 2'b00, 32'h0C, 32'h0);
    set_dma(1'b1, 2'b00, 32'h10, 32'h0);
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("stv_cpu_gnt%0d", i), {31'd0, cpu_gnt}, {31'd0, starve_cpu[i]});
      check($sformatf("stv_dma_gnt%0d", i), {31'd0, dma_gnt}, {31'd0, starve_dma[i]});
      check($sformatf("stv_onehot%0d", i), {31'd0, cpu_gnt & dma_gnt}, 32'd0);
      tick();
      check($sformatf("stv_dma_rvalid%0d", i), {31'd0, dma_rvalid}, {31'd0, starve_dma[i]});
    end
    check("stv_dma_rdata", dma_rdata, 32'h12345678);
    check("stv_cpu_rdata", cpu_rdata, 32'hBEEFAA00);

    // Reset with a response in flight and a partly-built starvation count.
    set_cpu(1'b0, 2'b00, 32'h0, 32'h0);
    set_dma(1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    set_cpu(1'b1, 2'b00, 32'h0, 32'h0);
    set_dma(1'b1, 2'b00, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("pre_cpu_gnt%0d", i), {31'd0, cpu_gnt}, 32'd1);
      tick();
    end
    reset = 1'b1;
    #1;
    check("mid_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("mid_dma_gnt", {31'd0, dma_gnt}, 32'd0);
    check("mid_mem_we", {30'd0, mem_we}, 32'd0);
    tick();
    check("mid_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("mid_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("mid_dma_rdata", dma_rdata, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("post_cpu_gnt%0d", i), {31'd0, cpu_gnt}, {31'd0, starve_cpu[i]});
      check($sformatf("post_dma_gnt%0d", i), {31'd0, dma_gnt}, {31'd0, starve_dma[i]});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
